pll_rst_seq: RTL and testbench

//  Reset sequencer wrapped around the system PLL, clocked by the free-running 50 MHz board clock

---
 rtl/pll_rst_seq.sv | 174 +++++++++++++++++
 tb/tb_pll_rst_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset sequencer wrapped around the system PLL.
// Pulses the PLL reset, waits for a debounced lock, then releases the
// staged active-low resets one at a time. Lock loss drops every stage at
// once and waits for relock; lock timeout or a software request restarts
// the whole sequence from the PLL reset.
// Optional build macro: PLL_RST_SEQ_LOSS_CNT_EN adds the lock_loss_cnt output.
//
// state      | meaning
// PLL_RST    | pll_rst high, PLL held in reset for PLL_RST_CYCLES
// WAIT_LOCK  | waiting for synced lock, timeout after LOCK_TIMEOUT cycles
// DEBOUNCE   | counting consecutive locked cycles up to LOCK_STABLE
// RELEASE    | releasing rst_n_out bits STAGE_GAP cycles apart
// RUN        | all stages released, ready high
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGES         = 3,
  parameter int STAGE_GAP      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              sw_rst_req,
  output logic              pll_rst,
  output logic [STAGES-1:0] rst_n_out,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  output logic [7:0]        lock_loss_cnt,
`endif
  output logic              ready
);

  // Last counter value used in RELEASE: one cycle after the final stage rises.
  localparam int REL_LAST = (STAGES - 1) * STAGE_GAP + 1;
  localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD   = (LOCK_STABLE > REL_LAST) ? LOCK_STABLE : REL_LAST;
  localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TC_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TC_STABLE  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TC_RELEASE = CNT_W'(REL_LAST);
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_DEBOUNCE  = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [1:0]        sync_q;
  logic              locked_s;
  logic [STAGES-1:0] stage_set;
  logic [STAGES-1:0] rst_n_out_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // Next-state decode; the software request outranks lock loss and timeout.
  always_comb begin
    state_nxt = state;
    if (sw_rst_req && (state != S_PLL_RST)) begin
      state_nxt = S_PLL_RST;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == TC_PLL_RST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_DEBOUNCE;
          end else if (cnt == TC_TIMEOUT) begin
            state_nxt = S_PLL_RST;
          end
        end
        S_DEBOUNCE: begin
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (cnt == TC_STABLE) begin
            state_nxt = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (cnt == TC_RELEASE) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) state_nxt = S_WAIT_LOCK;
        end
        default: state_nxt = S_PLL_RST;
      endcase
    end
  end

  // Shared counter: cleared on every state change, saturating otherwise, idle in RUN.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if ((state != S_RUN) && (cnt != CNT_TOP)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Stage release: bit i is set on the edge where the RELEASE count equals i*STAGE_GAP.
  always_comb begin
    stage_set = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_set[i] = (state == S_RELEASE) && (cnt == CNT_W'(i * STAGE_GAP));
    end
    if ((state_nxt == S_RELEASE) || (state_nxt == S_RUN)) begin
      rst_n_out_nxt = rst_n_out | stage_set;
    end else begin
      rst_n_out_nxt = '0;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_n_out <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= (state_nxt == S_PLL_RST);
      rst_n_out <= rst_n_out_nxt;
      ready     <= (state_nxt == S_RUN);
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic loss_evt;

  // A loss event is a WAIT_LOCK timeout or lock loss after release began,
  // unless a software restart in the same cycle takes precedence.
  always_comb begin
    loss_evt = 1'b0;
    if (!sw_rst_req && !locked_s) begin
      if ((state == S_WAIT_LOCK) && (cnt == TC_TIMEOUT)) loss_evt = 1'b1;
      if ((state == S_RELEASE) || (state == S_RUN))      loss_evt = 1'b1;
    end
  end

  // Saturating event counter, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_evt && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Testbench for pll_rst_seq with small parameters. A behavioural model
// tracks run lengths of the synced lock signal and elapsed time since
// release; a compare process checks every cycle, and directed scenarios
// pin the model with literal expectations.
module tb_pll_rst_seq;
  localparam int P_RST = 4;
  localparam int L_TO  = 20;
  localparam int L_ST  = 5;
  localparam int NSTG  = 3;
  localparam int GAP   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            pll_locked = 1'b0;
  logic            sw_rst_req = 1'b0;
  logic            pll_rst;
  logic            ready;
  logic [NSTG-1:0] rst_n_out;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0]      lock_loss_cnt;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  pll_rst_seq #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT(L_TO),
    .LOCK_STABLE(L_ST),
    .STAGES(NSTG),
    .STAGE_GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .pll_rst(pll_rst),
    .rst_n_out(rst_n_out),
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0: PLL reset pulse, 1: waiting for stable lock, 2: released.
  int m_phase, m_pr, m_lk, m_ul, m_rel, m_ls1, m_ls2, m_loss;

  task automatic model_reset();
    m_phase = 0; m_pr = 0; m_lk = 0; m_ul = 0; m_rel = 0;
    m_ls1 = 0; m_ls2 = 0; m_loss = 0;
  endtask

  task automatic model_bump();
    if (m_loss < 255) m_loss++;
  endtask

  task automatic model_step();
    int ls;
    ls = m_ls2;
    m_ls2 = m_ls1;
    m_ls1 = int'(pll_locked);
    if (sw_rst_req && m_phase != 0) begin
      m_phase = 0; m_pr = 0;
    end else begin
      case (m_phase)
        0: begin
          m_pr++;
          if (m_pr == P_RST) begin m_phase = 1; m_lk = 0; m_ul = 0; end
        end
        1: begin
          if (ls != 0) begin
            m_lk++;
            if (m_lk == L_ST + 1) begin m_phase = 2; m_rel = 0; end
          end else if (m_lk > 0) begin
            m_lk = 0; m_ul = 0;
          end else begin
            m_ul++;
            if (m_ul == L_TO) begin model_bump(); m_phase = 0; m_pr = 0; end
          end
        end
        default: begin
          if (ls == 0) begin
            model_bump(); m_phase = 1; m_lk = 0; m_ul = 0;
          end else if (m_rel < 1000) begin
            m_rel++;
          end
        end
      endcase
    end
  endtask

  function automatic logic [NSTG-1:0] m_out();
    logic [NSTG-1:0] v;
    v = '0;
    if (m_phase == 2)
      for (int i = 0; i < NSTG; i++) v[i] = (m_rel > i * GAP);
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_pll_rst", 32'(pll_rst), 32'(m_phase == 0));
      chk("cyc_rst_n_out", 32'(rst_n_out), 32'(m_out()));
      chk("cyc_ready", 32'(ready), 32'((m_phase == 2) && (m_rel >= (NSTG-1)*GAP + 2)));
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("cyc_lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
    end
  end

  task automatic run(input logic lkv, input int n);
    pll_locked = lkv;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s ready=0 expected=1 within 300 cycles", name);
    end
  endtask

  int rises[$];
  int fall_at;
  logic prev_r;
  int per, wid;
  bit found;

  initial begin
    // Power-up with lock already present.
    pll_locked = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pll_rst", 32'(pll_rst), 32'd1);
    chk("reset_rst_n_out", 32'(rst_n_out), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("pwrup_pll_rst", 32'(pll_rst), (k < 4) ? 32'd1 : 32'd0);
      chk("pwrup_rst_n_out", 32'(rst_n_out),
          (k >= 15) ? 32'd7 : (k >= 13) ? 32'd3 : (k >= 11) ? 32'd1 : 32'd0);
      chk("pwrup_ready", 32'(ready), (k >= 16) ? 32'd1 : 32'd0);
    end

    // Glitch during debounce delays release.
    @(posedge clk); #1;
    run(1'b0, 6);
    run(1'b1, 3);
    run(1'b0, 1);
    run(1'b1, 6);
    chk("glitch_rst_n_out", 32'(rst_n_out), 32'd0);
    chk("glitch_ready", 32'(ready), 32'd0);
    wait_ready("glitch_relock");

    // Lock timeout: pll_rst re-pulses 4 wide every 24 cycles.
    pll_locked = 1'b0;
    rises.delete();
    fall_at = -1;
    prev_r = 1'b0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (pll_rst && !prev_r) rises.push_back(n);
      if (!pll_rst && prev_r && rises.size() == 1 && fall_at < 0) fall_at = n;
      prev_r = pll_rst;
    end
    per = (rises.size() >= 2) ? rises[1] - rises[0] : -1;
    wid = (rises.size() >= 1 && fall_at >= 0) ? fall_at - rises[0] : -1;
    chk("timeout_period", 32'(per), 32'd24);
    chk("timeout_width", 32'(wid), 32'd4);
    pll_locked = 1'b1;
    wait_ready("relock_after_timeout");

    // Lock loss in RUN: outputs drop three edges after the pin.
    @(posedge clk); #1 pll_locked = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("loss_ready_before", 32'(ready), 32'd1);
    chk("loss_out_before", 32'(rst_n_out), 32'd7);
    @(negedge clk);
    chk("loss_ready_after", 32'(ready), 32'd0);
    chk("loss_out_after", 32'(rst_n_out), 32'd0);
    chk("loss_pll_rst", 32'(pll_rst), 32'd0);
    @(posedge clk); #1;
    run(1'b0, 4);
    pll_locked = 1'b1;
    wait_ready("relock_after_loss");

    // Software request coinciding with lock loss; second request in PLL_RST.
    @(posedge clk); #1 pll_locked = 1'b0;
    @(posedge clk); @(posedge clk); #1 sw_rst_req = 1'b1;
    @(posedge clk); #1 sw_rst_req = 1'b0;
    chk("sw_pll_rst_on", 32'(pll_rst), 32'd1);
    @(posedge clk); #1 sw_rst_req = 1'b1;
    @(posedge clk); #1 sw_rst_req = 1'b0;
    @(posedge clk); #1;
    chk("sw_pulse_last", 32'(pll_rst), 32'd1);
    @(posedge clk); #1;
    chk("sw_pulse_not_extended", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    wait_ready("relock_after_sw");

    // Asynchronous reset in the middle of RELEASE.
    @(posedge clk); #1;
    run(1'b0, 4);
    pll_locked = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(posedge clk); #1;
      if (rst_n_out == 3'b011) found = 1'b1;
    end
    chk("release_011_seen", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pll_rst", 32'(pll_rst), 32'd1);
    chk("async_rst_n_out", 32'(rst_n_out), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk("async_loss_cnt", 32'(lock_loss_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised lock behaviour with occasional software requests.
    for (int s = 0; s < 150; s++) begin
      int len;
      len = $urandom_range(1, 45);
      pll_locked = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < len; c++) begin
        sw_rst_req = ($urandom_range(0, 40) == 0);
        @(posedge clk); #1;
      end
      sw_rst_req = 1'b0;
    end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    // Drive well over 255 timeout events to reach saturation.
    run(1'b0, 300 * 24 + 30);
    chk("loss_cnt_saturated", 32'(lock_loss_cnt), 32'd255);
`endif

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
